// File: rtl/instr_fetch.sv
// ============================================================================
// Module   : instr_fetch
// Brief    : Instruction fetch stage. Holds the PC, issues word fetches over a
//            valid/ready request channel with in-order responses, buffers the
//            returned words in a small FIFO and hands {instr, pc, opcode} to
//            decode. Redirects flush buffered work and drop in-flight beats.
//            Optional macro FETCH_MISALIGN_CHECK_EN adds fetch_misaligned and
//            halts fetch after a redirect to a non-word-aligned target.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [6:0]  opcode
`ifdef FETCH_MISALIGN_CHECK_EN
  ,
  output logic        fetch_misaligned
`endif
);

  localparam int c_PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  // Counters are 4 bits: outstanding + dropped + buffered never exceed FIFO_DEPTH (<= 8)
  logic [31:0]        r_pc;
  logic [3:0]         r_outstanding;
  logic [3:0]         r_drop_cnt;
  logic [3:0]         r_count;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [31:0]        r_data [FIFO_DEPTH];
  logic [31:0]        r_epc  [FIFO_DEPTH];

  logic [4:0]         w_inflight;
  logic               w_halt;
  logic               w_req_valid;
  logic               w_req_fire;
  logic               w_drop_beat;
  logic               w_keep_beat;
  logic               w_push;
  logic               w_pop;
  logic [31:0]        w_rsp_pc;
  logic [31:0]        w_redirect_pc;
  logic [3:0]         w_redir_drops;

  function automatic logic [c_PTR_W-1:0] f_next(input logic [c_PTR_W-1:0] ptr);
    if (ptr == c_PTR_W'(FIFO_DEPTH - 1)) begin
      f_next = '0;
    end else begin
      f_next = ptr + 1'b1;
    end
  endfunction

`ifdef FETCH_MISALIGN_CHECK_EN
  logic r_misaligned;

  // Misalignment flag follows the alignment of the most recent redirect target
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_misaligned <= 1'b0;
    end else if (redirect_valid) begin
      r_misaligned <= |redirect_pc[1:0];
    end
  end

  assign fetch_misaligned = r_misaligned;
  assign w_halt           = r_misaligned;
  assign w_redirect_pc    = redirect_pc;
`else
  logic w_unused_pc_lsb;

  assign w_halt          = 1'b0;
  assign w_redirect_pc   = {redirect_pc[31:2], 2'b00};
  assign w_unused_pc_lsb = ^redirect_pc[1:0];
`endif

  // Everything already committed to a slot: in flight, awaiting drop, or buffered
  assign w_inflight   = {1'b0, r_outstanding} + {1'b0, r_drop_cnt} + {1'b0, r_count};
  assign w_req_valid  = rst_n && !redirect_valid && !w_halt && (w_inflight < 5'(FIFO_DEPTH));
  assign w_req_fire   = w_req_valid && mem_req_ready;

  // Stale beats (from before a redirect) are always the oldest, so drop them first
  assign w_drop_beat  = mem_rsp_valid && (r_drop_cnt != 4'd0);
  assign w_keep_beat  = mem_rsp_valid && (r_drop_cnt == 4'd0) && (r_outstanding != 4'd0);
  assign w_rsp_pc     = r_pc - (32'(r_outstanding) << 2);
  assign w_redir_drops = r_drop_cnt + r_outstanding;

  assign w_push = w_keep_beat && !redirect_valid;
  assign w_pop  = (r_count != 4'd0) && instr_ready && !redirect_valid;

  // PC, outstanding-request and drop accounting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc          <= RESET_PC;
      r_outstanding <= 4'd0;
      r_drop_cnt    <= 4'd0;
    end else if (redirect_valid) begin
      r_pc          <= w_redirect_pc;
      r_outstanding <= 4'd0;
      r_drop_cnt    <= w_redir_drops -
                       ((mem_rsp_valid && (w_redir_drops != 4'd0)) ? 4'd1 : 4'd0);
    end else begin
      if (w_req_fire) begin
        r_pc <= r_pc + 32'd4;
      end
      r_outstanding <= r_outstanding + 4'(w_req_fire) - 4'(w_keep_beat);
      if (w_drop_beat) begin
        r_drop_cnt <= r_drop_cnt - 4'd1;
      end
    end
  end

  // FIFO pointers and occupancy; a redirect empties the buffer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= 4'd0;
    end else if (redirect_valid) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= 4'd0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= f_next(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= f_next(r_rd_ptr);
      end
      r_count <= r_count + 4'(w_push) - 4'(w_pop);
    end
  end

  // Per-entry storage of instruction word and its PC
  for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
    // Capture a kept response beat into the slot addressed by the write pointer
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_data[gi] <= 32'd0;
        r_epc[gi]  <= 32'd0;
      end else if (w_push && (r_wr_ptr == c_PTR_W'(gi))) begin
        r_data[gi] <= mem_rsp_data;
        r_epc[gi]  <= w_rsp_pc;
      end
    end
  end

  assign mem_req_valid = w_req_valid;
  assign mem_req_addr  = r_pc;
  assign instr_valid   = (r_count != 4'd0);
  assign instr         = r_data[r_rd_ptr];
  assign instr_pc      = r_epc[r_rd_ptr];
  assign opcode        = r_data[r_rd_ptr][6:0];

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch.sv
// ============================================================================
// Module   : tb_instr_fetch
// Brief    : Self-checking bench for instr_fetch. A memory model answers
//            requests in order one cycle or more after acceptance; a
//            transaction-level model (epoch-tagged requests, buffered-entry
//            queue) predicts every output each cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_fetch;

  localparam int          DEPTH = 2;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  logic        clk;
  logic        rst_n;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [6:0]  opcode;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic        fetch_misaligned;
`endif

  instr_fetch #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_rsp_valid  (mem_rsp_valid),
    .mem_rsp_data   (mem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .opcode         (opcode)
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    .fetch_misaligned (fetch_misaligned)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          epoch;
  } req_t;

  typedef struct {
    logic [31:0] data;
    logic [31:0] pc;
  } ent_t;

  // Model state
  req_t        reqq[$];
  ent_t        bufq[$];
  logic [31:0] dlv[$];
  logic [31:0] rq_log[$];
  logic [31:0] exp_req_pc;
  int          epoch;
  logic        m_mis;

  // Stimulus knobs
  logic        tb_rd_v;
  logic [31:0] tb_rd_pc;
  logic        tb_rdy;
  logic        tb_mrdy;
  logic        tb_rsp_en;

  int n_chk;
  int n_pass;

  function automatic logic [31:0] memf(input logic [31:0] a);
    memf = (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    mem_rsp_valid  = 1'b0;
    mem_rsp_data   = 32'd0;
    mem_req_ready  = 1'b0;
    instr_ready    = 1'b0;
    #1;
    chk("rst_req_valid", 32'(mem_req_valid), 32'd0);
    chk("rst_req_addr", mem_req_addr, RPC);
    chk("rst_instr_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_instr_pc", instr_pc, 32'd0);
    chk("rst_opcode", 32'(opcode), 32'd0);
`ifdef FETCH_MISALIGN_CHECK_EN
    chk("rst_misaligned", 32'(fetch_misaligned), 32'd0);
`endif
    reqq.delete();
    bufq.delete();
    dlv.delete();
    rq_log.delete();
    exp_req_pc = RPC;
    epoch++;
    m_mis = 1'b0;
    tb_rd_v = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One clock: drive at the falling edge, compare 1ns later, advance the model
  task automatic cycle();
    logic exp_mrv;
    logic hs;
    logic pop;
    logic beat;
    logic kept;
    req_t e;
    redirect_valid = tb_rd_v;
    redirect_pc    = tb_rd_pc;
    instr_ready    = tb_rdy;
    mem_req_ready  = tb_mrdy;
    beat           = tb_rsp_en && (reqq.size() > 0);
    mem_rsp_valid  = beat;
    mem_rsp_data   = beat ? memf(reqq[0].addr) : 32'hDEAD_BEEF;
    #1;
    exp_mrv = !tb_rd_v && !m_mis && ((reqq.size() + bufq.size()) < DEPTH);
    chk("req_valid", 32'(mem_req_valid), 32'(exp_mrv));
    if (exp_mrv) chk("req_addr", mem_req_addr, exp_req_pc);
    chk("instr_valid", 32'(instr_valid), 32'(bufq.size() > 0));
    if (bufq.size() > 0) begin
      chk("instr", instr, bufq[0].data);
      chk("instr_pc", instr_pc, bufq[0].pc);
      chk("opcode", 32'(opcode), 32'(bufq[0].data[6:0]));
    end
`ifdef FETCH_MISALIGN_CHECK_EN
    chk("misaligned", 32'(fetch_misaligned), 32'(m_mis));
`endif
    hs   = exp_mrv && tb_mrdy;
    pop  = (bufq.size() > 0) && tb_rdy;
    kept = 1'b0;
    if (beat) begin
      e    = reqq.pop_front();
      kept = (e.epoch == epoch) && !tb_rd_v;
    end
    if (tb_rd_v) begin
      bufq.delete();
      epoch++;
`ifdef FETCH_MISALIGN_CHECK_EN
      exp_req_pc = tb_rd_pc;
      m_mis      = (tb_rd_pc[1:0] != 2'b00);
`else
      exp_req_pc = {tb_rd_pc[31:2], 2'b00};
`endif
    end else begin
      if (pop) begin
        dlv.push_back(bufq[0].pc);
        void'(bufq.pop_front());
      end
      if (kept) bufq.push_back('{data: memf(e.addr), pc: e.addr});
    end
    if (hs) begin
      reqq.push_back('{addr: exp_req_pc, epoch: epoch});
      rq_log.push_back(exp_req_pc);
      exp_req_pc = exp_req_pc + 32'd4;
    end
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic redirect(input logic [31:0] pc);
    tb_rd_v  = 1'b1;
    tb_rd_pc = pc;
    cycle();
    tb_rd_v  = 1'b0;
  endtask

  initial begin
    int mark;
    int found;
    n_chk     = 0;
    n_pass    = 0;
    epoch     = 0;
    m_mis     = 1'b0;
    tb_rd_v   = 1'b0;
    tb_rd_pc  = 32'd0;
    tb_rdy    = 1'b1;
    tb_mrdy   = 1'b1;
    tb_rsp_en = 1'b1;
    rst_n     = 1'b0;
    @(negedge clk);

    // Streaming fetch from reset
    do_reset();
    run(16);
    chk("seq_rq0", rq_log[0], 32'h0);
    chk("seq_rq2", rq_log[2], 32'h8);
    chk("seq_pc0", dlv[0], 32'h0);
    chk("seq_pc1", dlv[1], 32'h4);
    chk("seq_pc3", dlv[3], 32'hC);

    // Decode stalled: fill the buffer, then drain
    do_reset();
    tb_rdy = 1'b0;
    run(10);
    chk("stall_nreq", 32'(rq_log.size()), 32'd2);
    tb_rdy = 1'b1;
    run(8);
    chk("stall_pc0", dlv[0], 32'h0);
    chk("stall_pc1", dlv[1], 32'h4);
    chk("stall_rq2", rq_log[2], 32'h8);

    // Redirect with two fetches outstanding (mid-operation reset first)
    do_reset();
    tb_rsp_en = 1'b0;
    run(4);
    chk("outst_nreq", 32'(rq_log.size()), 32'd2);
    redirect(32'h0000_0100);
    tb_rsp_en = 1'b1;
    run(12);
    chk("redir_pc0", dlv[0], 32'h100);
    chk("redir_pc1", dlv[1], 32'h104);

    // Redirect coinciding with a response beat and a decode pop
    found = 0;
    for (int k = 0; k < 20 && found == 0; k++) begin
      if (bufq.size() > 0 && reqq.size() > 0) found = 1;
      else cycle();
    end
    chk("coincide_found", 32'(found), 32'd1);
    mark = dlv.size();
    redirect(32'h0000_0400);
    chk("coincide_empty", 32'(instr_valid), 32'd0);
    run(10);
    chk("coincide_pc0", dlv[mark], 32'h400);

    // Address wrap
    mark = dlv.size();
    redirect(32'hFFFF_FFF8);
    run(14);
    chk("wrap_pc0", dlv[mark], 32'hFFFF_FFF8);
    chk("wrap_pc1", dlv[mark+1], 32'hFFFF_FFFC);
    chk("wrap_pc2", dlv[mark+2], 32'h0000_0000);

`ifdef FETCH_MISALIGN_CHECK_EN
    redirect(32'h0000_0102);
    mark = rq_log.size();
    run(4);
    chk("mis_flag", 32'(fetch_misaligned), 32'd1);
    chk("mis_noreq", 32'(rq_log.size()), 32'(mark));
    redirect(32'h0000_0200);
    run(6);
    chk("mis_clear", 32'(fetch_misaligned), 32'd0);
    chk("mis_resume", rq_log[mark], 32'h200);
`endif

    // Randomised back-pressure, latency and aligned redirects
    for (int k = 0; k < 400; k++) begin
      tb_rd_v   = ($urandom_range(0, 19) == 0);
      tb_rd_pc  = $urandom() & 32'hFFFF_FFFC;
      tb_rdy    = ($urandom_range(0, 3) != 0);
      tb_mrdy   = ($urandom_range(0, 3) != 0);
      tb_rsp_en = ($urandom_range(0, 2) != 0);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
